// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined four-function W-bit logic unit with valid/ready handshake
// Results carry an illegal-select flag; co tracks the last legal select, count tallies deliveries.
module logic_unit_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   Sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         sel_err,
    output logic [1:0]   co,
    output logic [15:0]  count
);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] err_q, err_d;
    logic [W-1:0]      y_q [STAGES];
    logic [W-1:0]      y_d [STAGES];
    logic [STAGES-1:0] rdy;
    logic [1:0]        co_q, co_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [W-1:0]      f_y;
    logic              f_err;
    logic [1:0]        f_idx;
    logic              accept;
    logic              deliver;

    // A stage can load when it or any stage downstream of it has a hole, or the tail drains.
    always_comb begin
        logic full;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full = full & vld_q[j];
            end
            rdy[k] = out_ready | ~full;
        end
    end

    always_comb begin
        f_y   = '0;
        f_err = 1'b0;
        f_idx = 2'd0;
        case (Sel)
            4'b0001: begin f_y = ~(A & B); f_idx = 2'd0; end
            4'b0010: begin f_y = ~(A | B); f_idx = 2'd1; end
            4'b0100: begin f_y = A ^ B;    f_idx = 2'd2; end
            4'b1000: begin f_y = ~(A ^ B); f_idx = 2'd3; end
            default: f_err = 1'b1;
        endcase
    end

    assign in_ready  = ~rst & rdy[0];
    assign accept    = in_valid & in_ready;
    assign deliver   = vld_q[STAGES-1] & out_ready;
    assign out_valid = vld_q[STAGES-1];
    assign Y         = y_q[STAGES-1];
    assign sel_err   = err_q[STAGES-1];
    assign co        = co_q;
    assign count     = cnt_q;

    always_comb begin
        vld_d = vld_q;
        err_d = err_q;
        for (int k = 0; k < STAGES; k++) begin
            y_d[k] = y_q[k];
        end
        if (rdy[0]) begin
            vld_d[0] = in_valid;
            y_d[0]   = f_y;
            err_d[0] = f_err;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                vld_d[k] = vld_q[k-1];
                y_d[k]   = y_q[k-1];
                err_d[k] = err_q[k-1];
            end
        end
        co_d  = (accept && !f_err) ? f_idx : co_q;
        cnt_d = cnt_q + 16'(deliver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            co_q  <= 2'd0;
            cnt_q <= 16'd0;
            for (int k = 0; k < STAGES; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            co_q  <= co_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                y_q[k] <= y_d[k];
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe (W=8/STAGES=3 and W=1/STAGES=1)
module tb_logic_unit_pipe;
    localparam int W = 8;
    localparam int S = 3;

    typedef struct {
        logic [63:0] y;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic [3:0]   sel = '0;
    logic         in_ready, out_valid, sel_err;
    logic [W-1:0] y;
    logic [1:0]   co;
    logic [15:0]  count;

    logic         rst_b = 1'b1, iv_b = 1'b0, a_b = 1'b0, b_b = 1'b0;
    logic [3:0]   sel_b = '0;
    logic         b_in_ready, b_out_valid, b_y, b_sel_err;
    logic [1:0]   b_co;
    logic [15:0]  b_count;
    logic         b_done = 1'b0;

    logic [1:0]   co_exp = 2'd0, co_next = 2'd0;
    exp_t         sb_q[$];
    exp_t         sbb_q[$];
    int           tests = 0, fails = 0;

    logic_unit_pipe #(.W(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_i), .B(b_i), .Sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .Y(y), .sel_err(sel_err), .co(co), .count(count)
    );

    logic_unit_pipe #(.W(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(b_in_ready),
        .A(a_b), .B(b_b), .Sel(sel_b), .out_valid(b_out_valid), .out_ready(1'b1),
        .Y(b_y), .sel_err(b_sel_err), .co(b_co), .count(b_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bitwise truth tables indexed by {a,b}; legality is "exactly one select bit set".
    function automatic logic [63:0] model_y(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] s, output logic err,
                                            output logic [1:0] idx);
        logic [3:0]  tbl [4];
        logic [63:0] r;
        int          n;
        tbl[0] = 4'b0111; tbl[1] = 4'b0001; tbl[2] = 4'b0110; tbl[3] = 4'b1001;
        n = 0; idx = 2'd0; r = '0;
        for (int k = 0; k < 4; k++) if (s[k]) begin n++; idx = 2'(k); end
        err = (n != 1);
        if (!err) for (int i = 0; i < 64; i++) r[i] = tbl[idx][{a[i], b[i]}];
        return r;
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic ordy, input logic r,
                        output logic accepted);
        exp_t       e;
        logic [1:0] idx;
        @(posedge clk);
        #1;
        co_exp    = co_next;
        in_valid  = iv; a_i = a; b_i = b; sel = s; out_ready = ordy; rst = r;
        #3;
        accepted = in_valid && in_ready;
        if (r) begin
            chk("in_ready_during_rst", in_ready, 0);
            co_next = 2'd0;
        end else if (accepted) begin
            e.y = model_y(64'(a), 64'(b), s, e.err, idx);
            sb_q.push_back(e);
            if (!e.err) co_next = idx;
        end
    endtask

    task automatic rnd_op(output logic [W-1:0] a, output logic [W-1:0] b, output logic [3:0] s);
        a = W'($urandom);
        b = W'($urandom);
        if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
        else s = 4'b0001 << $urandom_range(0, 3);
    endtask

    task automatic idle(input int n);
        logic ac;
        repeat (n) step(1'b0, '0, '0, 4'd0, 1'b1, 1'b0, ac);
    endtask

    task automatic lat_test(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
        logic ac;
        step(1'b1, a, b, s, 1'b1, 1'b0, ac);
        chk("lat_accept", ac, 1);
        for (int j = 0; j < S; j++) begin
            step(1'b0, '0, '0, 4'd0, 1'b1, 1'b0, ac);
            chk("latency_out_valid", out_valid, (j >= S - 1) ? 1 : 0);
        end
    endtask

    // Monitor: checks every delivered result, counter and co, and hold-while-stalled.
    logic         stall_q = 1'b0, err_prev = 1'b0;
    logic [W-1:0] y_prev = '0;
    int           exp_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        chk("count", count, 64'(exp_cnt[15:0]));
        chk("co", co, co_exp);
        if (stall_q) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_y", y, y_prev);
            chk("stall_sel_err", sel_err, err_prev);
        end
        if (rst) begin
            sb_q.delete();
            exp_cnt = 0;
            stall_q = 1'b0;
        end else begin
            stall_q  = out_valid && !out_ready;
            y_prev   = y;
            err_prev = sel_err;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("y", y, e.y[W-1:0]);
                    chk("sel_err", sel_err, e.err);
                end
                exp_cnt = (exp_cnt + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b && b_out_valid) begin
            if (sbb_q.size() == 0) begin
                chk("w1_unexpected_result", 1, 0);
            end else begin
                e = sbb_q.pop_front();
                chk("w1_y", b_y, e.y[0]);
                chk("w1_sel_err", b_sel_err, e.err);
            end
        end
    end

    // Single-bit instance: exhaustive a/b against legal and illegal selects.
    initial begin
        logic [3:0]  sv [8];
        logic [1:0]  co_b_exp, idx;
        exp_t        e;
        sv = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h6, 4'hF, 4'hC};
        co_b_exp = 2'd0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            #1;
            rst_b = 1'b0; iv_b = 1'b1; a_b = i[0]; b_b = i[1]; sel_b = sv[i[4:2]];
            #3;
            chk("w1_in_ready", b_in_ready, 1);
            e.y = model_y(64'(a_b), 64'(b_b), sel_b, e.err, idx);
            sbb_q.push_back(e);
            if (!e.err) co_b_exp = idx;
            @(posedge clk);
        end
        #1 iv_b = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("w1_count", b_count, 32);
        chk("w1_co", b_co, co_b_exp);
        chk("w1_drained", sbb_q.size(), 0);
        b_done = 1'b1;
    end

    initial begin
        logic         ac;
        int           idx, n;
        logic [W-1:0] ra, rb;
        logic [3:0]   rs;
        logic [W-1:0] opa [5];
        logic [W-1:0] opb [5];
        logic [3:0]   ops [5];
        logic [3:0]   sweep [4];
        sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        step(1'b0, '0, '0, 4'd0, 1'b1, 1'b1, ac);
        step(1'b1, 8'h12, 8'h34, 4'b0001, 1'b1, 1'b1, ac);
        step(1'b0, '0, '0, 4'd0, 1'b1, 1'b0, ac);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("in_ready_after_rst", in_ready, 1);

        lat_test(8'hF0, 8'hCC, 4'b0100);
        foreach (sweep[i]) begin
            step(1'b1, 8'hF0, 8'hCC, sweep[i], 1'b1, 1'b0, ac);
            chk("sweep_accept", ac, 1);
        end
        idle(S + 1);
        chk("sweep_co", co, 3);
        chk("sweep_count", count, 5);

        step(1'b1, 8'hFF, 8'h00, 4'b0000, 1'b1, 1'b0, ac);
        step(1'b1, 8'hFF, 8'h00, 4'b0110, 1'b1, 1'b0, ac);
        idle(S + 1);
        chk("illegal_co_kept", co, 3);
        chk("illegal_count", count, 7);

        for (int i = 0; i < 5; i++) rnd_op(opa[i], opb[i], ops[i]);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, opa[idx], opb[idx], ops[idx], 1'b0, 1'b0, ac);
            if (ac) idx++;
        end
        chk("bp_accepted", idx, S);
        chk("bp_in_ready_full", in_ready, 0);
        n = 0;
        while (idx < 5 && n < 50) begin
            step(1'b1, opa[idx], opb[idx], ops[idx], 1'b1, 1'b0, ac);
            if (ac) idx++;
            n++;
        end
        chk("bp_all_accepted", idx, 5);
        idle(S + 2);
        chk("bp_drained", sb_q.size(), 0);

        for (int c = 0; c < S; c++) begin
            rnd_op(ra, rb, rs);
            step(1'b1, ra, rb, rs, 1'b0, 1'b0, ac);
            chk("fill_accept", ac, 1);
        end
        rnd_op(ra, rb, rs);
        step(1'b1, ra, rb, rs, 1'b1, 1'b0, ac);
        chk("full_in_ready", in_ready, 1);
        rnd_op(ra, rb, rs);
        step(1'b1, ra, rb, rs, 1'b0, 1'b0, ac);
        chk("full_still_full", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        idle(S + 2);

        for (int c = 0; c < 2; c++) begin
            rnd_op(ra, rb, rs);
            step(1'b1, ra, rb, rs, 1'b0, 1'b0, ac);
        end
        step(1'b1, 8'hAA, 8'h55, 4'b0010, 1'b1, 1'b1, ac);
        step(1'b0, '0, '0, 4'd0, 1'b1, 1'b0, ac);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        chk("midrst_count", count, 0);
        chk("midrst_co", co, 0);
        lat_test(8'h3C, 8'h0F, 4'b1000);
        idle(S + 1);

        for (int c = 0; c < 20; c++) begin
            rnd_op(ra, rb, rs);
            step(1'b1, ra, rb, rs, 1'b1, 1'b0, ac);
            chk("stream_in_ready", in_ready, 1);
        end
        for (int c = 0; c < 400; c++) begin
            rnd_op(ra, rb, rs);
            step(1'($urandom_range(0, 3) != 0), ra, rb, rs, 1'($urandom_range(0, 2) != 0), 1'b0, ac);
        end
        idle(S + 2);
        chk("random_drained", sb_q.size(), 0);

        step(1'b0, '0, '0, 4'd0, 1'b1, 1'b1, ac);
        for (int c = 0; c < 65537; c++) begin
            rnd_op(ra, rb, rs);
            step(1'b1, ra, rb, rs, 1'b1, 1'b0, ac);
            if (!ac) chk("wrap_accept", ac, 1);
        end
        idle(S + 1);
        chk("count_wrap", count, 16'h0001);
        chk("wrap_drained", sb_q.size(), 0);

        chk("w1_done", b_done, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the single-bit four-function logic cell. Operates on W-bit operand pairs, with a one-hot function select (NAND, NOR, XOR, XNOR), a valid/ready handshake on both sides and STAGES back-pressurable register stages. It also reports illegal selects and counts delivered results. It sits between the operand sequencer and the result checker in the logic-verification path.

## Interface
Parameters:
- W, default 8, operand/result width (1..64)
- STAGES, default 2, pipeline depth (1..4)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operand pair this cycle
- A  in  W  operand A
- B  in  W  operand B
- Sel  in  4  one-hot function select: bit0 NAND, bit1 NOR, bit2 XOR, bit3 XNOR
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- Y  out  W  result
- sel_err  out  1  result sideband: Sel was not exactly one-hot
- co  out  2  encoded index of Sel for the last legal accepted op
- count  out  16  number of results delivered

## Operation
- Accept occurs when in_valid && in_ready. Result is delivered when out_valid && out_ready.
- Function is evaluated bitwise on the accept cycle and written into stage 1:
  - Sel=0001: Y = ~(A & B)
  - Sel=0010: Y = ~(A | B)
  - Sel=0100: Y = A ^ B
  - Sel=1000: Y = ~(A ^ B)
- Any other Sel value (zero or multi-hot): Y=0 and sel_err=1 travel with that result. co is unchanged. The op is still accepted and delivered, never dropped.
- co updates on a legal accept to 0/1/2/3 for bit0/1/2/3.
- Stages: each of the STAGES stages holds a valid bit, Y and sel_err.
  - Stage k loads from stage k-1 when stage k is empty or stage k is advancing.
  - Last stage advances when out_ready=1.
  - Y, sel_err and out_valid are driven directly from the last stage.
- in_ready = ~rst & (stage 1 empty | stage 1 advancing). It is combinational from out_ready through the stage valid chain; no skid buffer.
- When full throughput is sustained (out_ready held 1), one result is delivered per cycle with no bubbles.
- Back-pressure: while out_valid=1 && out_ready=0, Y and sel_err hold stable and out_valid stays 1. Upstream stages fill; once all STAGES are valid, in_ready=0.
- count increments by 1 on each delivery and wraps from 0xFFFF to 0x0000. Illegal-select results are counted.
- Ordering: results are delivered strictly in accept order.

## Timing
- Reset (rst=1 sampled at a rising edge): all stage valids=0, out_valid=0, Y=0, sel_err=0, co=0, count=0. in_ready=0 while rst=1 and 1 in the first cycle after release.
- Reset mid-operation discards all in-flight results without delivering them. A handshake presented in a cycle with rst=1 is ignored.
- Latency: an op accepted at edge n is visible on Y with out_valid=1 after edge n+STAGES-1. It is therefore deliverable in the cycle following edge n+STAGES-1, assuming no stall.
- Simultaneous accept and deliver with all stages full: legal. in_ready=1 in that cycle because the last stage is advancing, and occupancy is unchanged.
- co and count change only at rising edges, never combinationally.

## Test plan
- Function sweep, W=8, STAGES=2, out_ready=1:
  - A=0xF0, B=0xCC with Sel=0001/0010/0100/1000 on four consecutive cycles -> Y=0x3F, 0x03, 0x3C, 0xC3.
  - First result valid one cycle after first accept.
  - co ends at 3; count ends at 4.
- Illegal select: Sel=0000 then Sel=0110 with A=0xFF, B=0x00 -> two results with Y=0x00, sel_err=1; co unchanged from its prior value; count +2.
- Back-pressure, STAGES=3:
  - Hold out_ready=0 and offer 5 ops -> exactly 3 accepted, in_ready=0 after the 3rd, Y stable.
  - Release out_ready -> the 5 results arrive in order, one per cycle after the pipeline refills, with no loss or duplication.
- Full-occupancy simultaneous accept/deliver: stages full, out_ready=1, in_valid=1 in the same cycle -> in_ready=1, one delivered and one accepted, occupancy stays STAGES.
- Reset mid-flight: 2 ops in flight, assert rst for 1 cycle -> out_valid=0, Y=0, count=0, co=0 next cycle; the old results never appear. A new op after reset is delivered with normal latency.
- count wrap: deliver 65537 results -> count reads 0x0001. Run with W=1 as well; the function outputs match the single-bit truth table.
